// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss engine: optional dirty-victim writeback, multi-beat line fetch, one-cycle line fill.
// Build option CRITICAL_WORD_FIRST_EN starts the fetch at the missing word and wraps.
module dcache_refill_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     victim_dirty,
  input  logic [ADDR_W-1:0]        victim_addr,
  input  logic [LINE_WORDS*32-1:0] victim_line,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     fill_we,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [LINE_WORDS*32-1:0] fill_line,
  output logic                     crit_valid,
  output logic [31:0]              crit_data
);
  localparam int CNT_W     = $clog2(LINE_WORDS);
  localparam int OFF_W     = CNT_W + 2;
  localparam int BASE_W    = ADDR_W - OFF_W;
  localparam int LINE_BITS = LINE_WORDS * 32;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       start_q, start_d;
  logic [BASE_W-1:0]      victim_base_q, victim_base_d;
  logic [BASE_W-1:0]      miss_base_q, miss_base_d;
  logic [LINE_BITS-1:0]   victim_line_q, victim_line_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic                   crit_valid_q, crit_valid_d;
  logic [31:0]            crit_data_q, crit_data_d;

  logic [CNT_W-1:0]       idx;
  logic                   crit_hit;
  logic                   rd_ack;
  logic                   last_beat;
  logic [31:0]            victim_word [LINE_WORDS];
  logic                   unused_bits;

  // Only the line base and word index of the incoming addresses matter.
  assign unused_bits = ^{miss_addr[1:0], victim_addr[OFF_W-1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
  assign idx      = start_q + cnt_q;
  assign crit_hit = (cnt_q == '0);
`else
  assign idx      = cnt_q;
  assign crit_hit = (cnt_q == start_q);
`endif

  assign rd_ack    = (state_q == S_RD) && mem_ack;
  assign last_beat = (cnt_q == LAST_BEAT);

  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign victim_word[gi] = victim_line_q[gi*32 +: 32];
      assign line_d[gi*32 +: 32] = (rd_ack && idx == CNT_W'(gi)) ? mem_rdata
                                                                  : line_q[gi*32 +: 32];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    victim_base_d = victim_base_q;
    miss_base_d   = miss_base_q;
    victim_line_d = victim_line_q;
    crit_valid_d  = 1'b0;
    crit_data_d   = crit_data_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          victim_base_d = victim_addr[ADDR_W-1:OFF_W];
          miss_base_d   = miss_addr[ADDR_W-1:OFF_W];
          victim_line_d = victim_line;
          start_d       = miss_addr[OFF_W-1:2];
          cnt_d         = '0;
          state_d       = victim_dirty ? S_WB : S_RD;
        end
      end
      S_WB: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (crit_hit) begin
            crit_valid_d = 1'b1;
            crit_data_d  = mem_rdata;
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      start_q       <= '0;
      victim_base_q <= '0;
      miss_base_q   <= '0;
      victim_line_q <= '0;
      line_q        <= '0;
      crit_valid_q  <= 1'b0;
      crit_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      victim_base_q <= victim_base_d;
      miss_base_q   <= miss_base_d;
      victim_line_q <= victim_line_d;
      line_q        <= line_d;
      crit_valid_q  <= crit_valid_d;
      crit_data_q   <= crit_data_d;
    end
  end

  // Beat outputs come straight from registered state, so they hold until acked.
  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_WB) || (state_q == S_RD);
  assign mem_we    = (state_q == S_WB);
  assign mem_addr  = (state_q == S_WB) ? {victim_base_q, cnt_q, 2'b00} :
                     (state_q == S_RD) ? {miss_base_q, idx, 2'b00} : '0;
  assign mem_wdata = (state_q == S_WB) ? victim_word[cnt_q] : '0;
  assign fill_we   = (state_q == S_FILL);
  assign fill_addr = {miss_base_q, {OFF_W{1'b0}}};
  assign fill_line = line_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;

endmodule
